// File: rtl/bcd_updown_switch_counter_pkg.sv
// Shared BCD constants and helpers for the up/down switch counter and its digit cells.
package bcd_counter_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    // Packed all-nines value for up to eight digits; unused upper nibbles stay zero.
    function automatic logic [31:0] bcd_all_nines(input int num_digits);
        logic [31:0] value;
        value = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < num_digits) begin
                value[4*i +: 4] = BCD_MAX;
            end
        end
        return value;
    endfunction

endpackage

// File: rtl/bcd_updown_switch_counter_digit.sv
// One BCD digit cell: steps up or down by one, rolling 9->0 and 0->9; i_Hold freezes it.
module bcd_digit
    import bcd_counter_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Clear,
    input  logic       i_Up,
    input  logic       i_Down,
    input  logic       i_Hold,
    output logic [3:0] o_Digit,
    output logic       o_AtMax,
    output logic       o_AtMin
);

    logic [3:0] digit_reg;

    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_Clear) begin
            digit_reg <= BCD_MIN;
        end else if (!i_Hold) begin
            if (i_Up) begin
                digit_reg <= (digit_reg == BCD_MAX) ? BCD_MIN : digit_reg + 4'd1;
            end else if (i_Down) begin
                digit_reg <= (digit_reg == BCD_MIN) ? BCD_MAX : digit_reg - 4'd1;
            end
        end
    end

    assign o_Digit = digit_reg;
    assign o_AtMax = (digit_reg == BCD_MAX);
    assign o_AtMin = (digit_reg == BCD_MIN);

endmodule

// File: rtl/bcd_updown_switch_counter.sv
// Multi-digit BCD up/down counter stepped by rising edges of two debounced switches,
// with optional hold-to-repeat and wrap or saturate behaviour at the range ends.
module bcd_updown_switch_counter
    import bcd_counter_pkg::*;
#(
    parameter int NUM_DIGITS    = 2,
    parameter bit SATURATE      = 1'b0,
    parameter bit REPEAT_EN     = 1'b0,
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic                    i_Inc,
    input  logic                    i_Dec,
    input  logic                    i_Clear,
    output logic [4*NUM_DIGITS-1:0] o_Digits,
    output logic                    o_Wrap,
    output logic                    o_Zero
);

    logic inc_reg;
    logic dec_reg;
    logic wrap_reg;
    logic inc_evt;
    logic dec_evt;
    logic switch_change;
    logic rep_inc;
    logic rep_dec;
    logic up_evt;
    logic down_evt;
    logic wrap_evt;
    logic clamp_hold;

    logic [NUM_DIGITS-1:0] at_max;
    logic [NUM_DIGITS-1:0] at_min;
    logic [NUM_DIGITS:0]   low_max;
    logic [NUM_DIGITS:0]   low_min;

    // Edge registers capture the switches even during reset, so a switch held
    // through reset is treated as already pressed.
    always_ff @(posedge i_Clk) begin
        inc_reg <= i_Inc;
        dec_reg <= i_Dec;
    end

    assign inc_evt       = i_Inc & ~inc_reg;
    assign dec_evt       = i_Dec & ~dec_reg;
    assign switch_change = (i_Inc ^ inc_reg) | (i_Dec ^ dec_reg);

    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int HW = $clog2(REPEAT_DELAY + 1);
            logic [HW-1:0] hold_reg;
            logic          one_held;
            logic          fire;

            assign one_held = i_Inc ^ i_Dec;
            // Fire on the cycle the count would reach REPEAT_DELAY, then reload so
            // the following fires are REPEAT_PERIOD apart.
            assign fire = one_held && !switch_change && !i_Clear
                          && (hold_reg == HW'(REPEAT_DELAY - 1));

            always_ff @(posedge i_Clk) begin
                if (i_Reset || i_Clear || switch_change) begin
                    hold_reg <= '0;
                end else if (one_held) begin
                    hold_reg <= fire ? HW'(REPEAT_DELAY - REPEAT_PERIOD) : hold_reg + HW'(1);
                end
            end

            assign rep_inc = fire & i_Inc;
            assign rep_dec = fire & i_Dec;
        end else begin : g_no_repeat
            assign rep_inc = 1'b0;
            assign rep_dec = 1'b0;
        end
    endgenerate

    // Opposing events in the same cycle cancel each other.
    assign up_evt   = (inc_evt | rep_inc) & ~(dec_evt | rep_dec);
    assign down_evt = (dec_evt | rep_dec) & ~(inc_evt | rep_inc);

    assign low_max[0] = 1'b1;
    assign low_min[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign low_max[gi+1] = low_max[gi] & at_max[gi];
            assign low_min[gi+1] = low_min[gi] & at_min[gi];

            bcd_digit u_digit (
                .i_Clk   (i_Clk),
                .i_Reset (i_Reset),
                .i_Clear (i_Clear),
                .i_Up    (up_evt & low_max[gi]),
                .i_Down  (down_evt & low_min[gi]),
                .i_Hold  (clamp_hold),
                .o_Digit (o_Digits[4*gi +: 4]),
                .o_AtMax (at_max[gi]),
                .o_AtMin (at_min[gi])
            );
        end
    endgenerate

    assign wrap_evt   = (up_evt & low_max[NUM_DIGITS]) | (down_evt & low_min[NUM_DIGITS]);
    assign clamp_hold = SATURATE & wrap_evt;

    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_Clear) begin
            wrap_reg <= 1'b0;
        end else begin
            wrap_reg <= wrap_evt;
        end
    end

    assign o_Wrap = wrap_reg;
    assign o_Zero = low_min[NUM_DIGITS];

endmodule

// File: tb/tb_bcd_updown_switch_counter.sv
// Scoreboard bench for the BCD switch counter across wrap, saturate, repeat and 4-digit builds.
module tb_bcd_updown_switch_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  inc_v, dec_v, clr_v;
    logic [7:0]  dig0, dig1, dig2;
    logic [15:0] dig3;
    logic [3:0]  wrap_v, zero_v;

    // dut 0: wrap, dut 1: saturate, dut 2: repeat, dut 3: four digits
    bcd_updown_switch_counter #(.NUM_DIGITS(2), .SATURATE(1'b0)) u_dut_wrap (
        .i_Clk(clk), .i_Reset(rst), .i_Inc(inc_v[0]), .i_Dec(dec_v[0]), .i_Clear(clr_v[0]),
        .o_Digits(dig0), .o_Wrap(wrap_v[0]), .o_Zero(zero_v[0]));
    bcd_updown_switch_counter #(.NUM_DIGITS(2), .SATURATE(1'b1)) u_dut_sat (
        .i_Clk(clk), .i_Reset(rst), .i_Inc(inc_v[1]), .i_Dec(dec_v[1]), .i_Clear(clr_v[1]),
        .o_Digits(dig1), .o_Wrap(wrap_v[1]), .o_Zero(zero_v[1]));
    bcd_updown_switch_counter #(.NUM_DIGITS(2), .REPEAT_EN(1'b1), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)) u_dut_rep (
        .i_Clk(clk), .i_Reset(rst), .i_Inc(inc_v[2]), .i_Dec(dec_v[2]), .i_Clear(clr_v[2]),
        .o_Digits(dig2), .o_Wrap(wrap_v[2]), .o_Zero(zero_v[2]));
    bcd_updown_switch_counter #(.NUM_DIGITS(4)) u_dut_four (
        .i_Clk(clk), .i_Reset(rst), .i_Inc(inc_v[3]), .i_Dec(dec_v[3]), .i_Clear(clr_v[3]),
        .o_Digits(dig3), .o_Wrap(wrap_v[3]), .o_Zero(zero_v[3]));

    int checks = 0;
    int failures = 0;

    int   cnt[4];
    logic prev_i[4];
    logic prev_d[4];

    typedef struct {
        int          sel;
        logic [15:0] digits;
        logic        wrap;
        string       name;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic i;
        logic d;
        logic c;
        logic rep;
    } stim_t;

    function automatic logic [15:0] to_bcd(input int value);
        logic [15:0] r;
        int v;
        v = value;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [17:0] observe(input int sel);
        case (sel)
            0:       return {8'h00, dig0, wrap_v[0], zero_v[0]};
            1:       return {8'h00, dig1, wrap_v[1], zero_v[1]};
            2:       return {8'h00, dig2, wrap_v[2], zero_v[2]};
            default: return {dig3, wrap_v[3], zero_v[3]};
        endcase
    endfunction

    // Drive one cycle of stimulus, advance the reference count, queue the expectation.
    task automatic step(input int sel, input stim_t s, input string name);
        int   range;
        logic up, dn, w;
        range = (sel == 3) ? 10000 : 100;
        inc_v[sel] = s.i;
        dec_v[sel] = s.d;
        clr_v[sel] = s.c;
        up = (s.i & ~prev_i[sel]) | s.rep;
        dn = s.d & ~prev_d[sel];
        w  = 1'b0;
        if (s.c) begin
            cnt[sel] = 0;
        end else if (up && !dn) begin
            if (cnt[sel] == range - 1) begin
                w = 1'b1;
                if (sel != 1) cnt[sel] = 0;
            end else begin
                cnt[sel] = cnt[sel] + 1;
            end
        end else if (dn && !up) begin
            if (cnt[sel] == 0) begin
                w = 1'b1;
                if (sel != 1) cnt[sel] = range - 1;
            end else begin
                cnt[sel] = cnt[sel] - 1;
            end
        end
        prev_i[sel] = s.i;
        prev_d[sel] = s.d;
        sb.push_back('{sel, to_bcd(cnt[sel]), w, name});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cnt[k]    = 0;
            prev_i[k] = inc_v[k];
            prev_d[k] = dec_v[k];
        end
    endtask

    task automatic test_reset();
        exp_t e;
        logic [17:0] got, req;
        do_reset();
        for (int k = 0; k < 4; k++) sb.push_back('{k, 16'h0000, 1'b0, "reset"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = observe(e.sel);
            req = {e.digits, e.wrap, 1'b1};
            checks++;
            if (got !== req) begin
                failures++;
                $display("FAIL %s dut%0d: got digits=%h wrap=%b zero=%b, required digits=%h wrap=%b zero=%b",
                         e.name, e.sel, got[17:2], got[1], got[0], req[17:2], req[1], req[0]);
            end
        end
    endtask

    task automatic test_inc_wrap();
        exp_t e;
        logic [17:0] got, req;
        for (int j = 0; j < 200; j++) begin
            step(0, '{(j % 2 == 0), 1'b0, 1'b0, 1'b0}, "inc_wrap");
            e = sb.pop_front();
            got = observe(e.sel);
            req = {e.digits, e.wrap, (e.digits == 16'h0)};
            checks++;
            if (got !== req) begin
                failures++;
                $display("FAIL %s dut%0d step%0d: got digits=%h wrap=%b zero=%b, required digits=%h wrap=%b zero=%b",
                         e.name, e.sel, j, got[17:2], got[1], got[0], req[17:2], req[1], req[0]);
            end
        end
    endtask

    task automatic test_dec_saturate();
        stim_t st[$];
        int    sel_q[$];
        exp_t  e;
        logic [17:0] got, req;
        st.push_back('{1'b0, 1'b0, 1'b1, 1'b0}); sel_q.push_back(0);
        for (int j = 0; j < 80; j++) begin
            st.push_back('{(j % 2 == 0), 1'b0, 1'b0, 1'b0}); sel_q.push_back(0);
        end
        st.push_back('{1'b0, 1'b1, 1'b0, 1'b0}); sel_q.push_back(0);
        st.push_back('{1'b0, 1'b0, 1'b0, 1'b0}); sel_q.push_back(0);
        st.push_back('{1'b0, 1'b0, 1'b1, 1'b0}); sel_q.push_back(0);
        st.push_back('{1'b0, 1'b1, 1'b0, 1'b0}); sel_q.push_back(0);
        st.push_back('{1'b0, 1'b0, 1'b0, 1'b0}); sel_q.push_back(0);
        st.push_back('{1'b0, 1'b1, 1'b0, 1'b0}); sel_q.push_back(1);
        st.push_back('{1'b0, 1'b0, 1'b0, 1'b0}); sel_q.push_back(1);
        for (int j = 0; j < 200; j++) begin
            st.push_back('{(j % 2 == 0), 1'b0, 1'b0, 1'b0}); sel_q.push_back(1);
        end
        foreach (st[n]) begin
            step(sel_q[n], st[n], "dec_saturate");
            e = sb.pop_front();
            got = observe(e.sel);
            req = {e.digits, e.wrap, (e.digits == 16'h0)};
            checks++;
            if (got !== req) begin
                failures++;
                $display("FAIL %s dut%0d step%0d: got digits=%h wrap=%b zero=%b, required digits=%h wrap=%b zero=%b",
                         e.name, e.sel, n, got[17:2], got[1], got[0], req[17:2], req[1], req[0]);
            end
        end
    endtask

    task automatic test_simultaneous();
        stim_t st[$];
        exp_t  e;
        logic [17:0] got, req;
        st.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
        for (int j = 0; j < 114; j++) st.push_back('{(j % 2 == 0), 1'b0, 1'b0, 1'b0});
        for (int j = 0; j < 3; j++) st.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
        st.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        for (int j = 0; j < 20; j++) st.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
        st.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        foreach (st[n]) begin
            step(0, st[n], "simultaneous_hold");
            e = sb.pop_front();
            got = observe(e.sel);
            req = {e.digits, e.wrap, (e.digits == 16'h0)};
            checks++;
            if (got !== req) begin
                failures++;
                $display("FAIL %s dut%0d step%0d: got digits=%h wrap=%b zero=%b, required digits=%h wrap=%b zero=%b",
                         e.name, e.sel, n, got[17:2], got[1], got[0], req[17:2], req[1], req[0]);
            end
        end
    endtask

    task automatic test_reset_held_clear();
        stim_t st[$];
        exp_t  e;
        logic [17:0] got, req;
        step(0, '{1'b1, 1'b0, 1'b0, 1'b0}, "pre_reset");
        void'(sb.pop_front());
        do_reset();
        for (int j = 0; j < 5; j++) st.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
        st.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        for (int j = 0; j < 24; j++) st.push_back('{(j % 2 == 0), 1'b0, 1'b0, 1'b0});
        st.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
        st.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        foreach (st[n]) begin
            step(0, st[n], "reset_held_clear");
            e = sb.pop_front();
            got = observe(e.sel);
            req = {e.digits, e.wrap, (e.digits == 16'h0)};
            checks++;
            if (got !== req) begin
                failures++;
                $display("FAIL %s dut%0d step%0d: got digits=%h wrap=%b zero=%b, required digits=%h wrap=%b zero=%b",
                         e.name, e.sel, n, got[17:2], got[1], got[0], req[17:2], req[1], req[0]);
            end
        end
    endtask

    task automatic test_repeat();
        stim_t st[$];
        exp_t  e;
        logic [17:0] got, req;
        do_reset();
        // Hold 30 cycles: counts at cycles 1, 11, 15, 19, 23, 27.
        for (int k = 1; k <= 30; k++)
            st.push_back('{1'b1, 1'b0, 1'b0, (k >= 11 && (k - 11) % 4 == 0)});
        st.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        for (int k = 1; k <= 12; k++) st.push_back('{1'b1, 1'b0, 1'b0, (k == 11)});
        for (int k = 13; k <= 32; k++) st.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
        st.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        foreach (st[n]) begin
            step(2, st[n], "repeat");
            e = sb.pop_front();
            got = observe(e.sel);
            req = {e.digits, e.wrap, (e.digits == 16'h0)};
            checks++;
            if (got !== req) begin
                failures++;
                $display("FAIL %s dut%0d step%0d: got digits=%h wrap=%b zero=%b, required digits=%h wrap=%b zero=%b",
                         e.name, e.sel, n, got[17:2], got[1], got[0], req[17:2], req[1], req[0]);
            end
        end
    endtask

    task automatic test_four_digit();
        stim_t st[$];
        exp_t  e;
        logic [17:0] got, req;
        for (int j = 0; j < 2000; j++) st.push_back('{(j % 2 == 0), 1'b0, 1'b0, 1'b0});
        st.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
        st.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        st.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
        st.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
        st.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        foreach (st[n]) begin
            step(3, st[n], "four_digit");
            e = sb.pop_front();
            got = observe(e.sel);
            req = {e.digits, e.wrap, (e.digits == 16'h0)};
            checks++;
            if (got !== req) begin
                failures++;
                $display("FAIL %s dut%0d step%0d: got digits=%h wrap=%b zero=%b, required digits=%h wrap=%b zero=%b",
                         e.name, e.sel, n, got[17:2], got[1], got[0], req[17:2], req[1], req[0]);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        inc_v = '0;
        dec_v = '0;
        clr_v = '0;
        @(negedge clk);
        test_reset();
        test_inc_wrap();
        test_dec_saturate();
        test_simultaneous();
        test_reset_held_clear();
        test_repeat();
        test_four_digit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
